// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry instruction queue that decouples fetch from decode.
// Fetch pushes with a valid/ready handshake and keeps running while decode
// stalls, until the queue is full. Flush drops everything that is queued or
// incoming. When the queue is empty, decode sees NOP_INST at address 0.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   in_valid_i   fetch presents inst_i / inst_addr_i
//   in_ready_o   queue can accept an entry this cycle (decoded from registered count)
//   inst_i       fetched instruction
//   inst_addr_i  address of inst_i
//   flush_i      redirect: discard queued and incoming entries
//   stall_i      decode cannot consume this cycle
//   out_valid_o  head entry valid at decode
//   inst_o       head instruction, NOP_INST when !out_valid_o
//   inst_addr_o  head address, 0 when !out_valid_o
//   count_o      number of occupied entries
module if_id_queue #(
  parameter int unsigned        INST_W   = 32,
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [INST_W-1:0]            inst_i,
  input  logic [ADDR_W-1:0]            inst_addr_i,
  input  logic                         flush_i,
  input  logic                         stall_i,
  output logic                         out_valid_o,
  output logic [INST_W-1:0]            inst_o,
  output logic [ADDR_W-1:0]            inst_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [INST_W-1:0] r_mem_inst [DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_push;
  logic w_pop;

  // Status outputs depend only on the registered count, so neither stall_i
  // nor flush_i has a combinational path to in_ready_o.
  assign in_ready_o  = (r_count < CNT_W'(DEPTH));
  assign out_valid_o = (r_count != '0);
  assign count_o     = r_count;

  // Muxing on count keeps outputs X-free even though storage has no reset.
  assign inst_o      = out_valid_o ? r_mem_inst[r_rd_ptr] : NOP_INST;
  assign inst_addr_o = out_valid_o ? r_mem_addr[r_rd_ptr] : '0;

  // Full blocks a push even when a pop happens in the same cycle.
  assign w_push = in_valid_i & in_ready_o & ~flush_i;
  assign w_pop  = out_valid_o & ~stall_i & ~flush_i;

  // Storage write; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= inst_i;
      r_mem_addr[r_wr_ptr] <= inst_addr_i;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: instance 0 has DEPTH=2, instance 1 has DEPTH=4.
// A queue-based reference model per instance tracks expected contents; a
// negedge monitor compares DUT status/head against it and logs consumed
// addresses so the driver can check ordering, loss and duplication.
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [1:0]  stall;
  logic [1:0]  flush;
  logic [1:0]  rdy;
  logic [1:0]  ov;
  logic [31:0] inst_in  [2];
  logic [31:0] addr_in  [2];
  logic [31:0] inst_out [2];
  logic [31:0] addr_out [2];
  logic [1:0]  cnt0;
  logic [2:0]  cnt1;

  int n_checks = 0;
  int n_errors = 0;
  logic rnd = 1'b0;

  logic [31:0] got0 [$];
  logic [31:0] got1 [$];
  logic [31:0] sent [$];

  always #5 clk = ~clk;

  if_id_queue #(.INST_W(32), .ADDR_W(32), .DEPTH(2), .NOP_INST(NOP)) u_d2 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid[0]), .in_ready_o(rdy[0]),
    .inst_i(inst_in[0]), .inst_addr_i(addr_in[0]),
    .flush_i(flush[0]), .stall_i(stall[0]),
    .out_valid_o(ov[0]), .inst_o(inst_out[0]), .inst_addr_o(addr_out[0]),
    .count_o(cnt0)
  );

  if_id_queue #(.INST_W(32), .ADDR_W(32), .DEPTH(4), .NOP_INST(NOP)) u_d4 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid[1]), .in_ready_o(rdy[1]),
    .inst_i(inst_in[1]), .inst_addr_i(addr_in[1]),
    .flush_i(flush[1]), .stall_i(stall[1]),
    .out_valid_o(ov[1]), .inst_o(inst_out[1]), .inst_addr_o(addr_out[1]),
    .count_o(cnt1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and monitor per instance.
  for (genvar g = 0; g < 2; g++) begin : g_sb
    localparam int unsigned D = (g == 0) ? 2 : 4;
    logic [63:0] q [$];

    // Queue semantics: flush empties, otherwise consume head then append.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        q.delete();
      end else if (flush[g]) begin
        q.delete();
      end else begin
        int sz;
        sz = q.size();
        if (sz != 0 && !stall[g]) void'(q.pop_front());
        if (in_valid[g] && sz < int'(D)) q.push_back({inst_in[g], addr_in[g]});
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        logic [3:0] c;
        c = (g == 0) ? 4'(cnt0) : 4'(cnt1);
        chk($sformatf("g%0d_count", g), 64'(c), 64'(q.size()));
        chk($sformatf("g%0d_count_le_depth", g), 64'(c <= 4'(D)), 64'(1));
        chk($sformatf("g%0d_in_ready", g), 64'(rdy[g]), 64'(q.size() < int'(D)));
        chk($sformatf("g%0d_out_valid", g), 64'(ov[g]), 64'(q.size() != 0));
        if (q.size() != 0)
          chk($sformatf("g%0d_head", g), {inst_out[g], addr_out[g]}, q[0]);
        else
          chk($sformatf("g%0d_empty_out", g), {inst_out[g], addr_out[g]}, {NOP, 32'h0});
        if (ov[g] && !stall[g] && !flush[g]) begin
          if (g == 0) got0.push_back(addr_out[g]);
          else        got1.push_back(addr_out[g]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int g, input logic [31:0] ad);
    in_valid[g] = 1'b1;
    addr_in[g]  = ad;
    inst_in[g]  = ad ^ 32'hA5A5_0000;
  endtask

  // Hold the presented entry until the queue takes it; bounded wait.
  task automatic wait_accept(input int g);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      if (rnd) stall[g] = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      acc = rdy[g] & ~flush[g];
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk($sformatf("g%0d_accept_timeout", g), 64'(0), 64'(1));
    in_valid[g] = 1'b0;
  endtask

  task automatic push_one(input int g, input logic [31:0] ad);
    present(g, ad);
    wait_accept(g);
  endtask

  task automatic rand_run(input int g, input int n, input logic [31:0] base);
    sent.delete();
    if (g == 0) got0.delete(); else got1.delete();
    rnd = 1'b1;
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) begin
        stall[g] = ($urandom_range(0, 2) == 0);
        tick();
      end
      sent.push_back(base + 32'(4 * k));
      push_one(g, base + 32'(4 * k));
    end
    rnd = 1'b0;
    stall[g] = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    if (g == 0) begin
      chk("g0_rand_len", 64'(got0.size()), 64'(sent.size()));
      for (int k = 0; k < sent.size() && k < got0.size(); k++)
        chk("g0_rand_order", 64'(got0[k]), 64'(sent[k]));
    end else begin
      chk("g1_rand_len", 64'(got1.size()), 64'(sent.size()));
      for (int k = 0; k < sent.size() && k < got1.size(); k++)
        chk("g1_rand_order", 64'(got1[k]), 64'(sent[k]));
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = '0;
    stall = '0;
    flush = '0;
    for (int g = 0; g < 2; g++) begin
      inst_in[g] = '0;
      addr_in[g] = '0;
    end
    tick();
    tick();
    // Reset state.
    chk("rst_out_valid", 64'(ov[0]), 64'(0));
    chk("rst_inst", 64'(inst_out[0]), 64'(NOP));
    chk("rst_addr", 64'(addr_out[0]), 64'(0));
    chk("rst_count", 64'(cnt0), 64'(0));
    chk("rst_ready", 64'(rdy[0]), 64'(1));
    rst = 1'b1;
    tick();

    // Pass-through with one-cycle latency.
    got0.delete();
    inst_in[0]  = 32'h0050_0093;
    addr_in[0]  = 32'h0000_0100;
    in_valid[0] = 1'b1;
    wait_accept(0);
    chk("pt_valid", 64'(ov[0]), 64'(1));
    chk("pt_inst", 64'(inst_out[0]), 64'(32'h0050_0093));
    chk("pt_addr", 64'(addr_out[0]), 64'(32'h100));
    tick();
    chk("pt_count_after_pop", 64'(cnt0), 64'(0));
    chk("pt_got", 64'(got0.size() == 1 && got0[0] == 32'h100), 64'(1));

    // Fill under stall, then release; includes pop-at-full refusal and push&pop at count 1.
    got0.delete();
    stall[0] = 1'b1;
    push_one(0, 32'h100);
    push_one(0, 32'h104);
    present(0, 32'h108);
    tick(); tick(); tick();
    chk("fill_count", 64'(cnt0), 64'(2));
    chk("fill_ready", 64'(rdy[0]), 64'(0));
    chk("fill_head", 64'(addr_out[0]), 64'(32'h100));
    stall[0] = 1'b0;
    tick();
    chk("full_pop_no_push_count", 64'(cnt0), 64'(1));
    chk("full_pop_head", 64'(addr_out[0]), 64'(32'h104));
    chk("ready_after_pop", 64'(rdy[0]), 64'(1));
    wait_accept(0);
    chk("pushpop_count", 64'(cnt0), 64'(1));
    chk("pushpop_head", 64'(addr_out[0]), 64'(32'h108));
    tick();
    chk("drain_count", 64'(cnt0), 64'(0));
    chk("fill_seq_len", 64'(got0.size()), 64'(3));
    if (got0.size() == 3) begin
      chk("fill_seq0", 64'(got0[0]), 64'(32'h100));
      chk("fill_seq1", 64'(got0[1]), 64'(32'h104));
      chk("fill_seq2", 64'(got0[2]), 64'(32'h108));
    end

    // Flush with a full queue and an incoming entry.
    got0.delete();
    stall[0] = 1'b1;
    push_one(0, 32'h200);
    push_one(0, 32'h204);
    present(0, 32'h208);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    in_valid[0] = 1'b0;
    chk("flush_count", 64'(cnt0), 64'(0));
    chk("flush_valid", 64'(ov[0]), 64'(0));
    chk("flush_inst", 64'(inst_out[0]), 64'(NOP));
    chk("flush_addr", 64'(addr_out[0]), 64'(0));
    stall[0] = 1'b0;
    tick(); tick(); tick();
    chk("flush_nothing_out", 64'(got0.size()), 64'(0));

    // Asynchronous reset mid-stream with count=2.
    stall[0] = 1'b1;
    push_one(0, 32'h300);
    push_one(0, 32'h304);
    chk("pre_rst_count", 64'(cnt0), 64'(2));
    #1 rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(ov[0]), 64'(0));
    chk("arst_inst", 64'(inst_out[0]), 64'(NOP));
    chk("arst_addr", 64'(addr_out[0]), 64'(0));
    chk("arst_count", 64'(cnt0), 64'(0));
    chk("arst_ready", 64'(rdy[0]), 64'(1));
    #1 rst = 1'b1;
    stall[0] = 1'b0;
    tick(); tick();

    // Randomized streams; DEPTH=4 exercises pointer wrap under random stall.
    rand_run(0, 20, 32'h1000);
    rand_run(1, 30, 32'h2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
